// File: rtl/da_idct_pkg.sv
// Shared constants, coefficient matrix and FSM encoding for the 4-point DA IDCT.
package da_idct_pkg;

    localparam int unsigned IDCT_DW    = 12;
    localparam int unsigned IDCT_ACC_W = 24;
    localparam int unsigned IDCT_FRAC  = 10;
    localparam int unsigned CNT_W      = 4;

    // Q1.10 weights; row k applies to Y0..Y3 in column order.
    localparam int COEF [4][4] = '{
        '{512,  669,  512,  277},
        '{512,  277, -512, -669},
        '{512, -277, -512,  669},
        '{512, -669,  512, -277}
    };

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/da_idct_rom.sv
// Combinational 16-entry coefficient-sum table for one output row.
module da_idct_rom
    import da_idct_pkg::*;
#(
    parameter int unsigned ROW = 0
) (
    input  logic        [3:0]         addr,
    output logic signed [IDCT_DW-1:0] data_c
);

    int sum;

    // addr[3] selects the Y0 weight, addr[0] selects the Y3 weight.
    always_comb begin
        sum = 0;
        for (int j = 0; j < 4; j++) begin
            if (addr[2'(3 - j)]) begin
                sum += COEF[ROW][j];
            end
        end
        data_c = IDCT_DW'(sum);
    end

endmodule

// File: rtl/da_idct4.sv
// Bit-serial distributed-arithmetic 4-point inverse DCT, MSB-first bit-planes.
module da_idct4
    import da_idct_pkg::*;
#(
    parameter int unsigned DW    = IDCT_DW,
    parameter int unsigned ACC_W = IDCT_ACC_W,
    parameter int unsigned FRAC  = IDCT_FRAC
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 idct_start,
    input  logic signed [DW-1:0] Y0,
    input  logic signed [DW-1:0] Y1,
    input  logic signed [DW-1:0] Y2,
    input  logic signed [DW-1:0] Y3,
    output logic                 busy,
    output logic                 idct_valid,
    output logic signed [DW-1:0] x0,
    output logic signed [DW-1:0] x1,
    output logic signed [DW-1:0] x2,
    output logic signed [DW-1:0] x3
);

    localparam logic signed [ACC_W-1:0] RND    = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);
    localparam logic [CNT_W-1:0]        CNT_MSB = CNT_W'(DW - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [DW-1:0]            ysh_q [4];
    logic signed [ACC_W-1:0]  acc_q [4];
    logic signed [DW-1:0]     tbl_c [4];
    logic signed [ACC_W-1:0]  ext_c [4];
    logic [3:0]               addr_c;
    logic                     busy_d, valid_d, load_c;

    // Round half up, then clamp to the output sample range.
    function automatic logic signed [DW-1:0] rnd_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = (a + RND) >>> FRAC;
        if (s > SAT_HI)      return DW'(SAT_HI);
        else if (s < SAT_LO) return DW'(SAT_LO);
        else                 return DW'(s);
    endfunction

    // Current bit-plane address taken from the shift-register MSBs.
    assign addr_c = {ysh_q[0][DW-1], ysh_q[1][DW-1], ysh_q[2][DW-1], ysh_q[3][DW-1]};

    for (genvar k = 0; k < 4; k++) begin : g_rom
        da_idct_rom #(.ROW(k)) u_rom (
            .addr   (addr_c),
            .data_c (tbl_c[k])
        );
    end

    // Sign-extend table entries to accumulator width.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ext_c[k] = {{(ACC_W - DW){tbl_c[k][DW-1]}}, tbl_c[k]};
        end
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and control decode; busy covers the DONE-to-IDLE cycle too.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (idct_start) begin
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                    load_c  = 1'b1;
                end
            end
            ST_CALC: begin
                busy_d = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shift registers, bit counter and accumulators; sign plane is subtracted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
            for (int k = 0; k < 4; k++) begin
                ysh_q[k] <= '0;
                acc_q[k] <= '0;
            end
        end else if (load_c) begin
            cnt_q    <= CNT_MSB;
            ysh_q[0] <= Y0;
            ysh_q[1] <= Y1;
            ysh_q[2] <= Y2;
            ysh_q[3] <= Y3;
            for (int k = 0; k < 4; k++) acc_q[k] <= '0;
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q - CNT_W'(1);
            for (int k = 0; k < 4; k++) begin
                ysh_q[k] <= {ysh_q[k][DW-2:0], 1'b0};
                if (cnt_q == CNT_MSB) acc_q[k] <= (acc_q[k] <<< 1) - ext_c[k];
                else                  acc_q[k] <= (acc_q[k] <<< 1) + ext_c[k];
            end
        end
    end

    // Registered outputs; samples update only on the DONE edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy       <= 1'b0;
            idct_valid <= 1'b0;
            x0         <= '0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
        end else begin
            busy       <= busy_d;
            idct_valid <= valid_d;
            if (valid_d) begin
                x0 <= rnd_sat(acc_q[0]);
                x1 <= rnd_sat(acc_q[1]);
                x2 <= rnd_sat(acc_q[2]);
                x3 <= rnd_sat(acc_q[3]);
            end
        end
    end

endmodule
